// File: rtl/rv_pkg.sv
// Shared definitions for the ready/valid pipeline: the state encoding of the
// two-entry buffer and the width of its occupancy count.
package rv_pkg;

  localparam int COUNT_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } rv_state_e;

  // Occupancy is the number of words held in each state
  function automatic logic [COUNT_W-1:0] state_count(input rv_state_e s);
    case (s)
      EMPTY:   return 2'd0;
      BUSY:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rv_skid_buffer_mod_register.sv
// Plain data register with load enable; clears on synchronous active-low reset.
module mod_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = en ? d : data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/rv_skid_buffer.sv
// Two-entry skid buffer: registered in_ready, out_valid and out_data, so no
// combinational path crosses the block while full throughput is kept.
module rv_skid_buffer
  import rv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] count
);

  rv_state_e        state_d, state_q;
  logic             in_ready_d, in_ready_q;
  logic             out_valid_d, out_valid_q;
  logic             main_en, main_from_skid, skid_en;
  logic [WIDTH-1:0] main_d, main_q, skid_q;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Skid word moves up to the head once the consumer takes the old head
        if (out_fire) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    main_d      = main_from_skid ? skid_q : in_data;
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  mod_register #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  mod_register #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = state_count(state_q);

endmodule

// File: doc/rv_skid_buffer.md
# rv_skid_buffer

Two-entry elastic buffer on a valid/ready channel, placed directly downstream of the ready/valid controller stage. It accepts words from the producer-side handshake and presents them to a consumer with registered ready and registered data, so neither ready nor data has a combinational path through the block. Full throughput (one word per cycle) is sustained while the consumer is ready; one backpressure cycle is absorbed without dropping data.

## Interface
- WIDTH, 16, data word width in bits
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low (sampled on posedge clk; asserted when 0)
- in_valid  in  1  producer offers in_data this cycle
- in_ready  out  1  block accepts; registered output
- in_data  in  WIDTH  producer word
- out_valid  out  1  out_data holds a valid word; registered
- out_ready  in  1  consumer takes out_data this cycle
- out_data  out  WIDTH  head word; registered
- count  out  2  words held: 0, 1 or 2

## Operation
- Input fire = in_valid & in_ready; output fire = out_valid & out_ready, both evaluated on the same posedge.
- Storage: main register (drives out_data) and skid register.
- States: EMPTY (count 0), BUSY (count 1, word in main), FULL (count 2, head in main, next word in skid).
- EMPTY: input fire -> main <= in_data, BUSY. Otherwise stay.
- BUSY: input fire & output fire -> main <= in_data, stay BUSY. Input fire only -> skid <= in_data, FULL. Output fire only -> EMPTY. Neither -> stay.
- FULL: in_ready is 0, so no input fire. Output fire -> main <= skid, BUSY. Otherwise hold both registers.
- in_ready next = 1 unless next state is FULL. out_valid next = 1 unless next state is EMPTY.
- Words leave in arrival order; no word is duplicated or dropped.
- Data registers update only on their load conditions. in_data is ignored when in_valid = 0.

## Timing
- Reset (rst = 0 at a posedge): state EMPTY, in_ready = 1, out_valid = 0, count = 0, main = 0, skid = 0. All values are visible after that edge.
- Reset mid-operation: held words are discarded, with no partial transfer. A handshake coinciding with the reset edge is ignored.
- Latency: a word accepted at edge N appears on out_data with out_valid = 1 after edge N, i.e. available to the consumer in cycle N+1.
- Throughput: with out_ready held 1, one word per cycle is sustained and the block stays in BUSY.
- Backpressure: one cycle with out_ready = 0 in BUSY while the producer keeps in_valid = 1 moves the block to FULL. in_ready drops to 0 the following cycle.
- Recovery: the first output fire in FULL returns in_ready to 1 the next cycle.
- Producer rule: in_valid and in_data may change only after an input fire or while in_valid = 0. The block holds out_valid and out_data stable until output fire.

## Structure
- Shared package rv_pkg holds the state typedef (EMPTY, BUSY, FULL; 2-bit encoding) and the count width constant. The upstream controller uses the same package.
- Sub-module: mod_register, instantiated twice (main and skid, WIDTH bits, with enable). The control FSM and the in_ready/out_valid flops live in this block.

## Test plan
- Reset: hold rst = 0 for two edges with in_valid = 1 and in_data = 16'hAAAA. Required: in_ready = 1, out_valid = 0, count = 0, out_data = 0, and nothing is accepted.
- Streaming: out_ready = 1, send 16'h0001..16'h0008 back to back. Required: the same sequence appears on out_data one cycle later, in_ready stays 1, and count stays 1.
- Skid: in BUSY holding 16'h0010, hold out_ready = 0 and push 16'h0011. Required: FULL, count = 2, in_ready = 0 the next cycle, out_data = 16'h0010. Then set out_ready = 1. Required: out_data = 16'h0011 with in_ready = 1, then EMPTY after one more fire.
- Simultaneous fire in BUSY (in 16'h0020, out 16'h001F). Required: state stays BUSY, out_data = 16'h0020, count = 1.
- Random stall: random in_valid and out_ready over 1000 cycles. Required: the output sequence equals the accepted input sequence exactly, and out_data never changes while out_valid = 1 and out_ready = 0.
- Mid-stream reset: assert rst = 0 while in FULL. Required: after the edge count = 0, out_valid = 0, in_ready = 1, and the old words never reappear.
